irb_scan: RTL and testbench

IRB_SCAN -- requirements
Module: irb_scan

---
 rtl/irb_pkg.sv | 15 +
 rtl/irb_mem.sv | 23 ++
 rtl/irb_scan.sv | 127 ++++++++++++
 tb/tb_irb_scan.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/irb_pkg.sv
// rtl/irb_pkg.sv - shared parameters and state encoding for the IR buffer scanner
package irb_pkg;
    localparam int IMG_W   = 8;
    localparam int IMG_PIX = 64;
    localparam int PIX_W   = 8;
    localparam int SUM_W   = 16;
    localparam int ADDR_W  = $clog2(IMG_PIX);
    localparam int X_W     = $clog2(IMG_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN
    } state_e;
endpackage

// File: rtl/irb_mem.sv
// rtl/irb_mem.sv - 64x8 pixel buffer, one synchronous write port, one registered read port
module irb_mem
    import irb_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [PIX_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [PIX_W-1:0]  rdata_o
);
    logic [PIX_W-1:0] mem_q [IMG_PIX];
    logic [PIX_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/irb_scan.sv
// rtl/irb_scan.sv - buffers a frame from the LCD controller and streams it to the panel
module irb_scan
    import irb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              IRB_RW,
    input  logic [ADDR_W-1:0] IRB_A,
    input  logic [PIX_W-1:0]  IRB_D,
    input  logic              done,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_data,
    output logic [X_W-1:0]    out_x,
    output logic [X_W-1:0]    out_y,
    output logic              frame_end,
    output logic [SUM_W-1:0]  checksum,
    output logic              wr_err,
    output logic              scan_busy
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [SUM_W-1:0]    checksum_q, checksum_d;
    logic [PIX_W-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_end_q, frame_end_d;
    logic                wr_err_q, wr_err_d;
    logic                done_d_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic [PIX_W-1:0]    rd_data;
    logic                mem_we;
    logic                accept;

    assign mem_we = !IRB_RW && (state_q == IDLE);
    assign accept = out_valid_q && out_ready;

    irb_mem u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (IRB_A),
        .wdata_i (IRB_D),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // The read port runs one pixel ahead of the outputs so an accept can load
    // the next pixel in the same edge; rd_addr is what rd_data holds after the edge.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        checksum_d  = checksum_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_end_d = 1'b0;
        wr_err_d    = wr_err_q | (!IRB_RW && (state_q != IDLE));
        rd_addr     = '0;
        case (state_q)
            IDLE: begin
                if (done && !done_d_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ptr_d   = '0;
                sum_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (!out_valid_q) begin
                    rd_addr     = ADDR_W'(1);
                    out_data_d  = rd_data;
                    out_valid_d = 1'b1;
                end else if (accept) begin
                    sum_d = sum_q + SUM_W'(out_data_q);
                    if (ptr_q == ADDR_W'(IMG_PIX - 1)) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        checksum_d  = sum_d;
                        frame_end_d = 1'b1;
                    end else begin
                        ptr_d      = ptr_q + ADDR_W'(1);
                        out_data_d = rd_data;
                        rd_addr    = ptr_q + ADDR_W'(2);
                    end
                end else begin
                    rd_addr = ptr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sum_q       <= '0;
            checksum_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
            wr_err_q    <= 1'b0;
            done_d_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            checksum_q  <= checksum_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_end_q <= frame_end_d;
            wr_err_q    <= wr_err_d;
            done_d_q    <= done;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_x     = ptr_q[X_W-1:0];
    assign out_y     = ptr_q[ADDR_W-1:X_W];
    assign frame_end = frame_end_q;
    assign checksum  = checksum_q;
    assign wr_err    = wr_err_q;
    assign scan_busy = (state_q == SCAN);
endmodule

// File: tb/tb_irb_scan.sv
// tb/tb_irb_scan.sv - scoreboard bench for irb_scan
module tb_irb_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IRB_RW = 1'b1;
    logic [5:0]  IRB_A = '0;
    logic [7:0]  IRB_D = '0;
    logic        done = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_x, out_y;
    logic        frame_end;
    logic [15:0] checksum;
    logic        wr_err;
    logic        scan_busy;

    int n_vec = 0;
    int n_err = 0;
    int beat_cnt = 0;

    logic [7:0]  img [64];
    logic [13:0] exp_q [$];
    logic [15:0] chk_q [$];

    irb_scan dut (
        .clk       (clk),
        .reset     (reset),
        .IRB_RW    (IRB_RW),
        .IRB_A     (IRB_A),
        .IRB_D     (IRB_D),
        .done      (done),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .frame_end (frame_end),
        .checksum  (checksum),
        .wr_err    (wr_err),
        .scan_busy (scan_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each accepted beat.
    logic       stall_pend = 1'b0;
    logic [7:0] st_data;
    logic [2:0] st_x, st_y;
    always @(negedge clk) begin
        if (!reset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'({out_data, out_y, out_x}), 32'({st_data, st_y, st_x}));
            end
            stall_pend = out_valid && !out_ready;
            st_data = out_data;
            st_x = out_x;
            st_y = out_y;
            if (out_valid && out_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    logic [13:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e[13:6]));
                    check("beat_xy", 32'({out_y, out_x}), 32'(e[5:0]));
                end
            end
            if (frame_end) begin
                check("end_valid_low", 32'(out_valid), 32'd0);
                if (chk_q.size() == 0) begin
                    check("unexpected_frame_end", 32'd1, 32'd0);
                end else begin
                    check("checksum", 32'(checksum), 32'(chk_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input bit all_ff);
        for (int a = 0; a < 64; a++) begin
            img[a] = all_ff ? 8'hFF : 8'(a);
            IRB_RW = 1'b0;
            IRB_A = 6'(a);
            IRB_D = img[a];
            tick();
        end
        IRB_RW = 1'b1;
    endtask

    task automatic push_frame();
        int s;
        s = 0;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({img[i], 6'(i)});
            s += int'(img[i]);
        end
        chk_q.push_back(16'(s));
    endtask

    task automatic wait_end(input bit toggle);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            tick();
            if (toggle) out_ready = ~out_ready;
            if (frame_end) seen = 1'b1;
        end
        check("frame_end_seen", 32'(seen), 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic run_frame(input bit toggle);
        push_frame();
        done = 1'b1;
        wait_end(toggle);
        done = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_xy", 32'({out_y, out_x}), 32'd0);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_busy", 32'(scan_busy), 32'd0);
    endtask

    initial begin
        bit got20;
        repeat (3) tick();
        check_reset_outputs();
        reset = 1'b1;
        tick();

        // Ramp frame, streaming and with back-pressure.
        write_frame(1'b0);
        run_frame(1'b0);
        run_frame(1'b1);
        check("wr_err_clean", 32'(wr_err), 32'd0);

        // Write during scan is ignored and flagged; held done does not retrigger.
        push_frame();
        done = 1'b1;
        repeat (4) tick();
        IRB_RW = 1'b0;
        IRB_A = 6'd5;
        IRB_D = 8'hAA;
        tick();
        IRB_RW = 1'b1;
        wait_end(1'b0);
        check("wr_err_set", 32'(wr_err), 32'd1);
        repeat (10) tick();
        check("no_retrigger_valid", 32'(out_valid), 32'd0);
        check("no_retrigger_busy", 32'(scan_busy), 32'd0);
        done = 1'b0;
        tick();
        run_frame(1'b0);
        check("wr_err_sticky", 32'(wr_err), 32'd1);

        // Reset in the middle of a scan, with done still high at release.
        beat_cnt = 0;
        push_frame();
        done = 1'b1;
        got20 = 1'b0;
        for (int c = 0; c < 200 && !got20; c++) begin
            tick();
            if (beat_cnt >= 20) got20 = 1'b1;
        end
        check("reached_beat20", 32'(got20), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        chk_q.delete();
        tick();
        tick();
        push_frame();
        reset = 1'b1;
        wait_end(1'b0);
        done = 1'b0;
        tick();
        tick();

        // Saturated frame, then a write coinciding with the done edge.
        write_frame(1'b1);
        run_frame(1'b0);
        img[0] = 8'h77;
        push_frame();
        IRB_RW = 1'b0;
        IRB_A = 6'd0;
        IRB_D = 8'h77;
        done = 1'b1;
        tick();
        IRB_RW = 1'b1;
        wait_end(1'b0);
        done = 1'b0;
        tick();
        check("final_checksum", 32'(checksum), 32'd16184);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("chk_q_drained", 32'(chk_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
